sw_debounce: RTL and testbench

SW_DEBOUNCE -- requirements
Module: sw_debounce

---
 rtl/sw_debounce.sv | 76 +++++++
 tb/tb_sw_debounce.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/sw_debounce.sv
// Ten-channel slide-switch debouncer.
// Each raw switch level passes through a two-flop synchronizer. A per-bit
// counter then measures how long the synchronized level has disagreed with
// the debounced output. The output bit only follows the synchronized level
// after DEBOUNCE_CYCLES consecutive disagreeing edges. A registered strobe
// and mask report which bits updated at the most recent edge.
module sw_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [9:0] SW_raw,
  output logic [9:0] SW,
  output logic       changed,
  output logic [9:0] change_mask
);

  // Counter width is ceil(log2(DEBOUNCE_CYCLES)).
  // The counter never needs to hold DEBOUNCE_CYCLES itself.
  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [9:0]    s1_r;
  logic [9:0]    s2_r;
  logic [CW-1:0] cnt_r    [10];
  logic [CW-1:0] cnt_next [10];
  logic [9:0]    sw_next;
  logic [9:0]    mask_next;

  // Per-bit debounce decision: clear on agreement, count on disagreement, accept at terminal count
  always_comb begin
    for (int i = 0; i < 10; i++) begin
      cnt_next[i]  = cnt_r[i];
      sw_next[i]   = SW[i];
      mask_next[i] = 1'b0;
      if (s2_r[i] == SW[i]) begin
        cnt_next[i] = CNT_ZERO;
      end else if (cnt_r[i] == CNT_MAX) begin
        // Terminal count: accept the new level and restart the counter.
        // Restarting also means the counter can never wrap.
        sw_next[i]   = s2_r[i];
        cnt_next[i]  = CNT_ZERO;
        mask_next[i] = 1'b1;
      end else begin
        cnt_next[i] = cnt_r[i] + CNT_ONE;
      end
    end
  end

  // State registers: synchronizer chain, counters, stable outputs and change strobe
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      s1_r        <= 10'h000;
      s2_r        <= 10'h000;
      SW          <= 10'h000;
      change_mask <= 10'h000;
      changed     <= 1'b0;
      for (int i = 0; i < 10; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
    end else begin
      // s1 -> s2 is a direct flop-to-flop path for metastability settling.
      s1_r        <= SW_raw;
      s2_r        <= s1_r;
      SW          <= sw_next;
      change_mask <= mask_next;
      changed     <= |mask_next;
      for (int i = 0; i < 10; i++) begin
        cnt_r[i] <= cnt_next[i];
      end
    end
  end

endmodule

// File: tb/tb_sw_debounce.sv
// Directed, table-driven bench for sw_debounce with DEBOUNCE_CYCLES = 4.
// Edge 0 is the first edge after SW_raw changes.
// With a two-flop synchronizer and four mismatching edges, SW updates at edge 5.
module tb_sw_debounce;

  localparam int unsigned N = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] sw_raw;
  logic [9:0] sw;
  logic       changed;
  logic [9:0] change_mask;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       rst;
    logic [9:0] raw;
    logic [9:0] sw;
    logic       ch;
    logic [9:0] mask;
  } vec_t;

  vec_t vecs[$];

  sw_debounce #(.DEBOUNCE_CYCLES(N)) dut (
    .CLOCK_50   (clk),
    .reset      (reset),
    .SW_raw     (sw_raw),
    .SW         (sw),
    .changed    (changed),
    .change_mask(change_mask)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [9:0] e_sw, input logic e_ch, input logic [9:0] e_mask);
    check({tag, " SW"}, sw, e_sw);
    check({tag, " changed"}, {9'h000, changed}, {9'h000, e_ch});
    check({tag, " mask"}, change_mask, e_mask);
  endtask

  task automatic add(input logic r, input logic [9:0] raw, input logic [9:0] e_sw, input logic e_ch, input logic [9:0] e_mask);
    vec_t v;
    v.rst = r; v.raw = raw; v.sw = e_sw; v.ch = e_ch; v.mask = e_mask;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    sw_raw = 10'h000;

    // Single-bit rise: edges 0..4 hold, edge 5 updates and pulses, edges 6..7 are quiet.
    add(1'b1, 10'h000, 10'h000, 1'b0, 10'h000);
    for (int e = 0; e < 5; e++) add(1'b0, 10'h001, 10'h000, 1'b0, 10'h000);
    add(1'b0, 10'h001, 10'h001, 1'b1, 10'h001);
    add(1'b0, 10'h001, 10'h001, 1'b0, 10'h000);
    add(1'b0, 10'h001, 10'h001, 1'b0, 10'h000);

    // All bits rise together, then bits 0 and 9 fall.
    add(1'b1, 10'h000, 10'h000, 1'b0, 10'h000);
    for (int e = 0; e < 5; e++) add(1'b0, 10'h3FF, 10'h000, 1'b0, 10'h000);
    add(1'b0, 10'h3FF, 10'h3FF, 1'b1, 10'h3FF);
    add(1'b0, 10'h3FF, 10'h3FF, 1'b0, 10'h000);
    for (int e = 0; e < 5; e++) add(1'b0, 10'h1FE, 10'h3FF, 1'b0, 10'h000);
    add(1'b0, 10'h1FE, 10'h1FE, 1'b1, 10'h201);
    add(1'b0, 10'h1FE, 10'h1FE, 1'b0, 10'h000);

    // Reset state, then raw held at 0 for 20 cycles produces nothing.
    do_reset();
    check_all("reset", 10'h000, 1'b0, 10'h000);
    for (int c = 0; c < 20; c++) begin
      step();
      check_all("idle", 10'h000, 1'b0, 10'h000);
    end

    // Table-driven vectors.
    for (int k = 0; k < vecs.size(); k++) begin
      reset  = vecs[k].rst;
      sw_raw = vecs[k].raw;
      step();
      check_all($sformatf("vec%0d", k), vecs[k].sw, vecs[k].ch, vecs[k].mask);
    end
    reset = 1'b0;

    // Bounce on bit 3: three cycles high, three low, five times.
    sw_raw = 10'h000;
    do_reset();
    for (int r = 0; r < 5; r++) begin
      sw_raw = 10'h008;
      for (int c = 0; c < 3; c++) begin
        step();
        check_all("bounce hi", 10'h000, 1'b0, 10'h000);
      end
      sw_raw = 10'h000;
      for (int c = 0; c < 3; c++) begin
        step();
        check_all("bounce lo", 10'h000, 1'b0, 10'h000);
      end
    end
    for (int c = 0; c < 6; c++) begin
      step();
      check_all("bounce tail", 10'h000, 1'b0, 10'h000);
    end

    // Reset mid-count on bit 4 at edge 3.
    // Edge 4 is the first post-reset sample, so the update lands at edge 9.
    sw_raw = 10'h000;
    do_reset();
    sw_raw = 10'h010;
    for (int e = 0; e < 3; e++) begin
      step();
      check_all("pre-rst", 10'h000, 1'b0, 10'h000);
    end
    reset = 1'b1;
    step();
    check_all("mid-rst", 10'h000, 1'b0, 10'h000);
    reset = 1'b0;
    for (int e = 4; e < 9; e++) begin
      step();
      check_all($sformatf("post-rst e%0d", e), 10'h000, 1'b0, 10'h000);
    end
    step();
    check_all("post-rst e9", 10'h010, 1'b1, 10'h010);
    step();
    check_all("post-rst e10", 10'h010, 1'b0, 10'h000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
